alu_multicycle: RTL and testbench
=================================

// Module: alu_multicycle
// PURPOSE
//  Parametrised successor to the single-cycle datapath ALU.
//  - Adds MIPS multiply/divide (MULT/MULTU/DIV/DIVU) with internal HI/LO registers, plus MFHI/MFLO reads.
//  - Adds a start/busy/done handshake and registered results/flags.
//  - Sits in the EX stage; the hazard unit stalls the pipeline while busy=1.
// PARAMETERS
//  WIDTH   32  datapath width in bits; >=8, power of 2
//  SHW     $clog2(WIDTH)  shift-amount width (derived; do not override)
// PORTS
//  CLK         in   1      clock, rising edge
//  nRST        in   1      synchronous active-low reset
//  start       in   1      request; sampled only when busy=0
//  aluop       in   4      opcode (aluop_t)
//  port_a      in   WIDTH  operand A; shift amount = port_a[SHW-1:0]
//  port_b      in   WIDTH  operand B
//  output_port out  WIDTH  registered result; held until next done
//  zero        out  1      output_port=='0, registered with result
//  negative    out  1      output_port[WIDTH-1], registered
//  overflow    out  1      signed overflow, ADD/SUB only, else 0
//  busy        out  1      high while a mul/div is in flight
//  done        out  1      1-cycle pulse: result/flags valid this cycle
// BEHAVIOUR
//  Reset (nRST=0 at an edge):
//  - all outputs 0; HI=LO=0; FSM->IDLE; iteration counter 0.
//  - Reset mid-operation aborts; HI/LO are not updated.
//  Opcodes:
//  - 0000 SLL B<<A  | 0001 SRL B>>A  | 0010 ADD  | 0011 SUB  | 0100 AND
//  - 0101 OR | 0110 XOR | 0111 NOR | 1010 SLT (signed) | 1011 SLTU
//  - 1000 MULT | 1001 MULTU | 1100 DIV | 1101 DIVU | 1110 MFHI | 1111 MFLO
//  - Overflow: ADD sets it when operand sign bits match and result sign differs; SUB when A,B signs differ and result sign!=A sign.
//  - All arithmetic is modulo 2^WIDTH.
//  Handshake:
//  - start with busy=0 is accepted at edge e0.
//  - Simple ops, MFHI, MFLO: result written at e0; done=1 for the cycle after e0; busy stays 0. Back-to-back starts give done every cycle.
//  - MULT/MULTU/DIV/DIVU: busy=1 from e0; result written at e(WIDTH+1); done=1 and busy=0 in the following cycle. Latency WIDTH+2 cycles.
//  - start while busy=1 is ignored; no queueing.
//  - Undefined aluop (none remain in 4 bits) -> result 0, done still pulses.
//  FSM:
//  - IDLE -> MUL | DIV on an accepted mul/div op.
//  - MUL|DIV: WIDTH iterations, counter 0..WIDTH-1, then -> FIX.
//  - FIX: sign correction, HI/LO written -> IDLE.
//  Arithmetic:
//  - Signed ops work on magnitudes, then negate in FIX.
//    Product sign = sa^sb. Quotient sign = sa^sb. Remainder sign = sa.
//  - MULT/MULTU: {HI,LO} = full 2*WIDTH-bit product (shift-add, 1 bit/cycle).
//  - DIV/DIVU: restoring division, LO=quotient, HI=remainder.
//  - Divide by zero: LO='1, HI=A. Same latency; the same iterate path produces it.
//  - DIV MIN/-1: LO=MIN, HI=0; no trap.
//  - output_port for mul/div = LO. zero/negative reflect LO; overflow=0.
//  - MFHI/MFLO issued in the same cycle as a done from mul/div return the new HI/LO (HI/LO are written before the edge sampling the read).
// STRUCTURE
//  - Package alu_pkg: aluop_t enum (above encodings), fsm_t {IDLE,MUL,DIV,FIX}, WIDTH default constant.
//  - Sub-module alu_comb_core: the combinational simple-op unit (result + overflow), reused by the single-cycle pipeline.
//  - Top holds the FSM, counter, shift/accumulator registers, HI/LO and output registers.
// TESTING  (WIDTH=32)
//  1. ADD 7FFFFFFF+1 start -> next cycle done=1, out=80000000, overflow=1, negative=1, busy=0.
//  2. MULT FFFFFFFE(-2)*3 -> done exactly 34 cycles after start. Then MFHI=FFFFFFFF, MFLO=FFFFFFFA.
//  3. DIV -7/2 -> LO=FFFFFFFD, HI=FFFFFFFF; DIVU 7/0 -> LO=FFFFFFFF, HI=7, latency 34.
//  4. start SUB at cycle 5 of a MULTU -> ignored; one done only; MULTU FFFFFFFF*FFFFFFFF -> HI=FFFFFFFE, LO=1.
//  5. nRST=0 at cycle 10 of DIV -> next cycle busy=0, done=0, out=0; MFHI/MFLO then return 0.
//  6. DIV 80000000/FFFFFFFF -> LO=80000000, HI=0; SLT FFFFFFFF,1 -> 1; SLTU -> 0.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcode/state types and width constant for the multicycle ALU
package alu_pkg;

    localparam int ALU_WIDTH = 32;

    typedef enum logic [3:0] {
        ALU_SLL   = 4'b0000,
        ALU_SRL   = 4'b0001,
        ALU_ADD   = 4'b0010,
        ALU_SUB   = 4'b0011,
        ALU_AND   = 4'b0100,
        ALU_OR    = 4'b0101,
        ALU_XOR   = 4'b0110,
        ALU_NOR   = 4'b0111,
        ALU_MULT  = 4'b1000,
        ALU_MULTU = 4'b1001,
        ALU_SLT   = 4'b1010,
        ALU_SLTU  = 4'b1011,
        ALU_DIV   = 4'b1100,
        ALU_DIVU  = 4'b1101,
        ALU_MFHI  = 4'b1110,
        ALU_MFLO  = 4'b1111
    } aluop_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } fsm_t;

    function automatic logic is_muldiv(input aluop_t op);
        return (op == ALU_MULT) || (op == ALU_MULTU) || (op == ALU_DIV) || (op == ALU_DIVU);
    endfunction

endpackage

// File: rtl/alu_comb_core.sv
// rtl/alu_comb_core.sv - combinational single-cycle ALU ops (result + signed overflow)
module alu_comb_core
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  aluop_t           aluop,
    input  logic [WIDTH-1:0] port_a,
    input  logic [WIDTH-1:0] port_b,
    output logic [WIDTH-1:0] result,
    output logic             overflow
);
    localparam int SHW = $clog2(WIDTH);

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;

    assign sum  = port_a + port_b;
    assign diff = port_a - port_b;

    always_comb begin
        result   = '0;
        overflow = 1'b0;
        case (aluop)
            ALU_SLL:  result = port_b << port_a[SHW-1:0];
            ALU_SRL:  result = port_b >> port_a[SHW-1:0];
            ALU_ADD: begin
                result   = sum;
                overflow = (port_a[WIDTH-1] == port_b[WIDTH-1]) && (sum[WIDTH-1] != port_a[WIDTH-1]);
            end
            ALU_SUB: begin
                result   = diff;
                overflow = (port_a[WIDTH-1] != port_b[WIDTH-1]) && (diff[WIDTH-1] != port_a[WIDTH-1]);
            end
            ALU_AND:  result = port_a & port_b;
            ALU_OR:   result = port_a | port_b;
            ALU_XOR:  result = port_a ^ port_b;
            ALU_NOR:  result = ~(port_a | port_b);
            ALU_SLT:  result = {{(WIDTH-1){1'b0}}, ($signed(port_a) < $signed(port_b))};
            ALU_SLTU: result = {{(WIDTH-1){1'b0}}, (port_a < port_b)};
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/alu_multicycle.sv
// rtl/alu_multicycle.sv - EX-stage ALU with iterative MULT/DIV, HI/LO and start/busy/done handshake
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             start,
    input  aluop_t           aluop,
    input  logic [WIDTH-1:0] port_a,
    input  logic [WIDTH-1:0] port_b,
    output logic [WIDTH-1:0] output_port,
    output logic             zero,
    output logic             negative,
    output logic             overflow,
    output logic             busy,
    output logic             done
);
    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);

    fsm_t               state_q, state_d;
    logic [SHW-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0] p_q, p_d;
    logic [WIDTH-1:0]   mag_q, mag_d;
    logic               is_div_q, is_div_d;
    logic               neg_hi_q, neg_hi_d;
    logic               neg_lo_q, neg_lo_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [WIDTH-1:0]   out_q, out_d;
    logic               zero_q, zero_d;
    logic               neg_q, neg_d;
    logic               ovf_q, ovf_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [WIDTH-1:0]   core_result;
    logic               core_ovf;

    alu_comb_core #(.WIDTH(WIDTH)) u_core (
        .aluop    (aluop),
        .port_a   (port_a),
        .port_b   (port_b),
        .result   (core_result),
        .overflow (core_ovf)
    );

    // Signed ops iterate on magnitudes; signs are reapplied in FIX.
    logic             op_signed, sa, sb;
    logic [WIDTH-1:0] mag_a, mag_b;

    assign op_signed = (aluop == ALU_MULT) || (aluop == ALU_DIV);
    assign sa        = op_signed & port_a[WIDTH-1];
    assign sb        = op_signed & port_b[WIDTH-1];
    assign mag_a     = sa ? -port_a : port_a;
    assign mag_b     = sb ? -port_b : port_b;

    // p_q is {acc, multiplier} for MUL and {remainder, dividend/quotient} for DIV.
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_cand;
    logic [WIDTH:0]   div_diff;
    logic             div_ge;
    logic [WIDTH-1:0] div_rem;

    assign mul_sum  = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, mag_q} : '0);
    assign div_cand = p_q[2*WIDTH-1:WIDTH-1];
    assign div_diff = div_cand - {1'b0, mag_q};
    assign div_ge   = ~div_diff[WIDTH];
    assign div_rem  = div_ge ? div_diff[WIDTH-1:0] : div_cand[WIDTH-1:0];

    logic [2*WIDTH-1:0] p_neg;
    logic [WIDTH-1:0]   fix_hi, fix_lo;

    assign p_neg = -p_q;

    always_comb begin
        fix_hi = p_q[2*WIDTH-1:WIDTH];
        fix_lo = p_q[WIDTH-1:0];
        if (is_div_q) begin
            if (neg_hi_q) fix_hi = -p_q[2*WIDTH-1:WIDTH];
            if (neg_lo_q) fix_lo = -p_q[WIDTH-1:0];
        end else if (neg_lo_q) begin
            {fix_hi, fix_lo} = p_neg;
        end
    end

    logic             res_load;
    logic [WIDTH-1:0] res_val;
    logic             res_ovf;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        p_d      = p_q;
        mag_d    = mag_q;
        is_div_d = is_div_q;
        neg_hi_d = neg_hi_q;
        neg_lo_d = neg_lo_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        busy_d   = busy_q;
        res_load = 1'b0;
        res_val  = '0;
        res_ovf  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (is_muldiv(aluop)) begin
                        is_div_d = (aluop == ALU_DIV) || (aluop == ALU_DIVU);
                        busy_d   = 1'b1;
                        cnt_d    = '0;
                        if (is_div_d) begin
                            state_d  = DIV;
                            p_d      = {{WIDTH{1'b0}}, mag_a};
                            mag_d    = mag_b;
                            // Divide by zero keeps the all-ones quotient unsigned.
                            neg_lo_d = (sa ^ sb) & (port_b != '0);
                            neg_hi_d = sa;
                        end else begin
                            state_d  = MUL;
                            p_d      = {{WIDTH{1'b0}}, mag_b};
                            mag_d    = mag_a;
                            neg_lo_d = sa ^ sb;
                            neg_hi_d = sa ^ sb;
                        end
                    end else begin
                        res_load = 1'b1;
                        res_ovf  = core_ovf;
                        case (aluop)
                            ALU_MFHI: res_val = hi_q;
                            ALU_MFLO: res_val = lo_q;
                            default:  res_val = core_result;
                        endcase
                    end
                end
            end
            MUL: begin
                p_d   = {mul_sum, p_q[WIDTH-1:1]};
                cnt_d = cnt_q + SHW'(1);
                if (cnt_q == LAST) state_d = FIX;
            end
            DIV: begin
                p_d   = {div_rem, p_q[WIDTH-2:0], div_ge};
                cnt_d = cnt_q + SHW'(1);
                if (cnt_q == LAST) state_d = FIX;
            end
            FIX: begin
                hi_d     = fix_hi;
                lo_d     = fix_lo;
                res_load = 1'b1;
                res_val  = fix_lo;
                busy_d   = 1'b0;
                cnt_d    = '0;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase

        out_d  = res_load ? res_val : out_q;
        zero_d = res_load ? (res_val == '0) : zero_q;
        neg_d  = res_load ? res_val[WIDTH-1] : neg_q;
        ovf_d  = res_load ? res_ovf : ovf_q;
        done_d = res_load;
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            p_q      <= '0;
            mag_q    <= '0;
            is_div_q <= 1'b0;
            neg_hi_q <= 1'b0;
            neg_lo_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            out_q    <= '0;
            zero_q   <= 1'b0;
            neg_q    <= 1'b0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            p_q      <= p_d;
            mag_q    <= mag_d;
            is_div_q <= is_div_d;
            neg_hi_q <= neg_hi_d;
            neg_lo_q <= neg_lo_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            out_q    <= out_d;
            zero_q   <= zero_d;
            neg_q    <= neg_d;
            ovf_q    <= ovf_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign output_port = out_q;
    assign zero        = zero_q;
    assign negative    = neg_q;
    assign overflow    = ovf_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// tb/tb_alu_multicycle.sv - randomized and directed checks of alu_multicycle against an arithmetic model
module tb_alu_multicycle;
    import alu_pkg::*;

    localparam int W = 32;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    logic         CLK = 1'b0;
    logic         nRST = 1'b0;
    logic         start = 1'b0;
    aluop_t       aluop = ALU_SLL;
    logic [W-1:0] port_a = '0;
    logic [W-1:0] port_b = '0;
    logic [W-1:0] output_port;
    logic         zero, negative, overflow, busy, done;

    int n_pass  = 0;
    int n_total = 0;

    always #5 CLK = ~CLK;

    alu_multicycle #(.WIDTH(W)) dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .start       (start),
        .aluop       (aluop),
        .port_a      (port_a),
        .port_b      (port_b),
        .output_port (output_port),
        .zero        (zero),
        .negative    (negative),
        .overflow    (overflow),
        .busy        (busy),
        .done        (done)
    );

    logic [W-1:0] m_hi = '0, m_lo = '0, m_out = '0, pend_hi = '0, pend_lo = '0;
    logic         m_zero = 1'b0, m_neg = 1'b0, m_ovf = 1'b0, m_busy = 1'b0, m_done = 1'b0;
    int           m_left = 0;

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at t=%0t", name, got, exp, $time);
    endtask

    function automatic void ref_simple(input aluop_t op, input logic [W-1:0] a, input logic [W-1:0] b,
                                       output logic [W-1:0] r, output logic ov);
        longint s;
        r  = '0;
        ov = 1'b0;
        case (op)
            ALU_SLL:  r = b << a[4:0];
            ALU_SRL:  r = b >> a[4:0];
            ALU_ADD: begin
                s  = longint'($signed(a)) + longint'($signed(b));
                r  = W'(s);
                ov = (s > SMAX) || (s < SMIN);
            end
            ALU_SUB: begin
                s  = longint'($signed(a)) - longint'($signed(b));
                r  = W'(s);
                ov = (s > SMAX) || (s < SMIN);
            end
            ALU_AND:  r = a & b;
            ALU_OR:   r = a | b;
            ALU_XOR:  r = a ^ b;
            ALU_NOR:  r = ~(a | b);
            ALU_SLT:  r = {31'b0, ($signed(a) < $signed(b))};
            ALU_SLTU: r = {31'b0, (a < b)};
            ALU_MFHI: r = m_hi;
            ALU_MFLO: r = m_lo;
            default:  r = '0;
        endcase
    endfunction

    function automatic void ref_muldiv(input aluop_t op, input logic [W-1:0] a, input logic [W-1:0] b,
                                       output logic [W-1:0] hi, output logic [W-1:0] lo);
        longint    sp;
        logic [63:0] p;
        int        q, rr;
        hi = '0;
        lo = '0;
        case (op)
            ALU_MULT: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                p  = sp;
                {hi, lo} = p;
            end
            ALU_MULTU: begin
                p = {32'b0, a} * {32'b0, b};
                {hi, lo} = p;
            end
            ALU_DIV: begin
                if (b == 0) begin
                    hi = a; lo = '1;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    hi = '0; lo = 32'h8000_0000;
                end else begin
                    q  = $signed(a) / $signed(b);
                    rr = $signed(a) % $signed(b);
                    lo = q; hi = rr;
                end
            end
            default: begin
                if (b == 0) begin
                    hi = a; lo = '1;
                end else begin
                    lo = a / b; hi = a % b;
                end
            end
        endcase
    endfunction

    task automatic set_result(input logic [W-1:0] r, input logic ov);
        m_out  = r;
        m_zero = (r == 0);
        m_neg  = r[W-1];
        m_ovf  = ov;
        m_done = 1'b1;
    endtask

    task automatic model_edge(input logic rn, input logic st, input aluop_t op,
                              input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] r;
        logic         ov;
        m_done = 1'b0;
        if (!rn) begin
            m_hi = '0; m_lo = '0; m_out = '0;
            m_zero = 1'b0; m_neg = 1'b0; m_ovf = 1'b0; m_busy = 1'b0;
            m_left = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_hi = pend_hi;
                m_lo = pend_lo;
                set_result(pend_lo, 1'b0);
                m_busy = 1'b0;
            end
        end else if (st) begin
            if (is_muldiv(op)) begin
                ref_muldiv(op, a, b, pend_hi, pend_lo);
                m_left = W + 1;
                m_busy = 1'b1;
            end else begin
                ref_simple(op, a, b, r, ov);
                set_result(r, ov);
            end
        end
    endtask

    task automatic step(input logic rn, input logic st, input aluop_t op,
                        input logic [W-1:0] a, input logic [W-1:0] b);
        nRST = rn; start = st; aluop = op; port_a = a; port_b = b;
        @(posedge CLK);
        model_edge(rn, st, op, a, b);
        #1;
        check("busy",     32'(busy),     32'(m_busy));
        check("done",     32'(done),     32'(m_done));
        check("out",      output_port,   m_out);
        check("zero",     32'(zero),     32'(m_zero));
        check("negative", 32'(negative), 32'(m_neg));
        check("overflow", 32'(overflow), 32'(m_ovf));
    endtask

    task automatic run_op(input aluop_t op, input logic [W-1:0] a, input logic [W-1:0] b, output int lat);
        step(1'b1, 1'b1, op, a, b);
        lat = 1;
        while (!done && lat < 60) begin
            step(1'b1, 1'b0, op, a, b);
            lat++;
        end
        if (!done) begin
            n_total++;
            $display("FAIL done_timeout: op %0d no done after %0d cycles", op, lat);
        end
    endtask

    function automatic logic [W-1:0] rnd_operand();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return 32'h8000_0000;
            2:       return '1;
            3:       return 32'h7FFF_FFFF;
            4:       return W'($urandom_range(0, 9));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int lat;
        int dones;

        step(1'b0, 1'b0, ALU_SLL, '0, '0);
        check("reset_out", output_port, 32'h0);
        check("reset_busy", 32'(busy), 32'h0);

        run_op(ALU_ADD, 32'h7FFF_FFFF, 32'h1, lat);
        check("add_lat", 32'(lat), 32'd1);
        check("add_out", output_port, 32'h8000_0000);
        check("add_ovf", 32'(overflow), 32'h1);
        check("add_neg", 32'(negative), 32'h1);
        check("add_busy", 32'(busy), 32'h0);

        run_op(ALU_MULT, 32'hFFFF_FFFE, 32'h3, lat);
        check("mult_lat", 32'(lat), 32'd34);
        run_op(ALU_MFHI, '0, '0, lat);
        check("mult_hi", output_port, 32'hFFFF_FFFF);
        run_op(ALU_MFLO, '0, '0, lat);
        check("mult_lo", output_port, 32'hFFFF_FFFA);

        run_op(ALU_DIV, 32'hFFFF_FFF9, 32'h2, lat);
        check("div_lo", output_port, 32'hFFFF_FFFD);
        run_op(ALU_MFHI, '0, '0, lat);
        check("div_hi", output_port, 32'hFFFF_FFFF);
        run_op(ALU_DIVU, 32'h7, 32'h0, lat);
        check("divz_lat", 32'(lat), 32'd34);
        check("divz_lo", output_port, 32'hFFFF_FFFF);
        run_op(ALU_MFHI, '0, '0, lat);
        check("divz_hi", output_port, 32'h7);

        dones = 0;
        step(1'b1, 1'b1, ALU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        for (int i = 1; i < 40; i++) begin
            step(1'b1, (i == 4), ALU_SUB, 32'h5, 32'h3);
            if (done) dones++;
        end
        check("ignored_start_dones", 32'(dones), 32'd1);
        run_op(ALU_MFHI, '0, '0, lat);
        check("multu_hi", output_port, 32'hFFFF_FFFE);
        run_op(ALU_MFLO, '0, '0, lat);
        check("multu_lo", output_port, 32'h1);

        step(1'b1, 1'b1, ALU_DIV, 32'd100, 32'd7);
        for (int i = 1; i < 10; i++) step(1'b1, 1'b0, ALU_DIV, 32'd100, 32'd7);
        step(1'b0, 1'b0, ALU_DIV, 32'd100, 32'd7);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_out", output_port, 32'h0);
        run_op(ALU_MFHI, '0, '0, lat);
        check("rst_hi", output_port, 32'h0);
        run_op(ALU_MFLO, '0, '0, lat);
        check("rst_lo", output_port, 32'h0);

        run_op(ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat);
        check("divmin_lo", output_port, 32'h8000_0000);
        run_op(ALU_MFHI, '0, '0, lat);
        check("divmin_hi", output_port, 32'h0);
        run_op(ALU_SLT, 32'hFFFF_FFFF, 32'h1, lat);
        check("slt", output_port, 32'h1);
        run_op(ALU_SLTU, 32'hFFFF_FFFF, 32'h1, lat);
        check("sltu", output_port, 32'h0);

        for (int c = 0; c < 4000; c++) begin
            step(($urandom_range(0, 299) != 0), ($urandom_range(0, 2) != 0),
                 aluop_t'(4'($urandom_range(0, 15))), rnd_operand(), rnd_operand());
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
